// File: rtl/lfsr_arb.sv
// Two-requester round-robin arbiter that serves each grant with a byte drawn from an 8-bit XNOR LFSR.
// Optional build macro LFSR_ARB_FREERUN_EN: the LFSR also advances every idle cycle without a seed load.
module lfsr_arb #(
    parameter int unsigned STEPS = 8
) (
    input  logic       Clk,
    input  logic       RS,
    input  logic [1:0] Req,
    input  logic       SeedLd,
    input  logic [7:0] Seed,
    output logic [1:0] Gnt,
    output logic       Valid,
    output logic [7:0] Dout,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] STEPS_C = 4'(STEPS);

    state_t     state_q, state_d;
    logic [7:0] q_q,     q_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       ptr_q,   ptr_d;
    logic [1:0] gnt_q,   gnt_d;
    logic       valid_q, valid_d;
    logic [7:0] dout_q,  dout_d;

    logic       sel_idx;
    logic [7:0] q_step;

    // XNOR feedback: the all-ones word is the only lock-up state, so it is kept out via the seed path.
    always_comb begin
        q_step = {q_q[6:0], ~(q_q[7] ^ q_q[6] ^ q_q[5] ^ q_q[1] ^ q_q[0])};
    end

    // Preferred requester wins if asking, otherwise the other one.
    always_comb begin
        sel_idx = Req[ptr_q] ? ptr_q : ~ptr_q;
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        valid_d = 1'b0;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (SeedLd) begin
                    q_d = (Seed == 8'hFF) ? 8'h00 : Seed;
                end else begin
`ifdef LFSR_ARB_FREERUN_EN
                    q_d = q_step;
`endif
                    if (Req != 2'b00) begin
                        gnt_d   = sel_idx ? 2'b10 : 2'b01;
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // One extra settle cycle after the last shift lets Dout/Valid register together.
                if (cnt_q == STEPS_C) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dout_d  = q_q;
                end else begin
                    q_d   = q_step;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                ptr_d   = ~gnt_q[1];
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RS) begin
            state_q <= IDLE;
            q_q     <= 8'h00;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            valid_q <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    assign Gnt   = gnt_q;
    assign Valid = valid_q;
    assign Dout  = dout_q;
    assign Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_arb.sv
// Directed bench for lfsr_arb (STEPS=8, free-run disabled); expected bytes hand-derived from the LFSR recurrence.
module tb_lfsr_arb;

    logic       Clk;
    logic       RS;
    logic [1:0] Req;
    logic       SeedLd;
    logic [7:0] Seed;
    logic [1:0] Gnt;
    logic       Valid;
    logic [7:0] Dout;
    logic       Busy;

    int compared   = 0;
    int mismatched = 0;

    lfsr_arb #(.STEPS(8)) dut (
        .Clk    (Clk),
        .RS     (RS),
        .Req    (Req),
        .SeedLd (SeedLd),
        .Seed   (Seed),
        .Gnt    (Gnt),
        .Valid  (Valid),
        .Dout   (Dout),
        .Busy   (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full grant: Req must already be driven. disturb>0 drops Req and pulses SeedLd at that shift cycle.
    task automatic do_txn(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_dout,
                          input int disturb);
        int n;
        tick();
        chk({tag, ".gnt"}, 32'(Gnt), 32'(exp_gnt));
        chk({tag, ".busy"}, 32'(Busy), 32'd1);
        for (n = 1; n <= 20; n++) begin
            if (n == disturb) begin
                Req    = 2'b00;
                SeedLd = 1'b1;
                Seed   = 8'h55;
            end else begin
                SeedLd = 1'b0;
            end
            tick();
            if (Valid) break;
        end
        SeedLd = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'd9);
        chk({tag, ".dout"}, 32'(Dout), 32'(exp_dout));
        chk({tag, ".gnt_held"}, 32'(Gnt), 32'(exp_gnt));
        $display("txn %s: gnt=%b dout=%h after %0d cycles", tag, Gnt, Dout, n);
        tick();
        chk({tag, ".valid_off"}, 32'(Valid), 32'd0);
        chk({tag, ".gnt_off"}, 32'(Gnt), 32'd0);
        chk({tag, ".idle"}, 32'(Busy), 32'd0);
        chk({tag, ".dout_hold"}, 32'(Dout), 32'(exp_dout));
    endtask

    initial begin
        RS = 1'b0; Req = 2'b00; SeedLd = 1'b0; Seed = 8'h00;
        tick();
        tick();
        chk("rst.gnt", 32'(Gnt), 32'd0);
        chk("rst.valid", 32'(Valid), 32'd0);
        chk("rst.dout", 32'(Dout), 32'd0);
        chk("rst.busy", 32'(Busy), 32'd0);
        RS = 1'b1;
        tick();

        // Single requester from the reset state: 00 -> 01 02 04 09 12 24 48 90.
        Req = 2'b01;
        do_txn("single", 2'b01, 8'h90, 0);
        Req = 2'b00;
        tick();

        // Both requesting: pointer now favours requester 1, then strict alternation.
        Req = 2'b11;
        do_txn("rr0", 2'b10, 8'h09, 0);
        do_txn("rr1", 2'b01, 8'h00, 0);
        do_txn("rr2", 2'b10, 8'h90, 0);
        Req = 2'b00;
        tick();
        tick();
        chk("idle.hold_dout", 32'(Dout), 32'h90);
        chk("idle.valid", 32'(Valid), 32'd0);

        // Lock-up seed is replaced by zero and the same-cycle request waits a cycle.
        SeedLd = 1'b1; Seed = 8'hFF; Req = 2'b10;
        tick();
        chk("seedff.no_gnt", 32'(Gnt), 32'd0);
        chk("seedff.busy", 32'(Busy), 32'd0);
        SeedLd = 1'b0;
        do_txn("seedff", 2'b10, 8'h90, 0);
        Req = 2'b00;

        // Ordinary seed 09 -> byte 00; pointer back on requester 0.
        SeedLd = 1'b1; Seed = 8'h09;
        tick();
        SeedLd = 1'b0; Req = 2'b01;
        do_txn("seed09", 2'b01, 8'h00, 0);
        Req = 2'b00;

        // Reset landing on the 4th shift cycle aborts the byte.
        Req = 2'b01;
        tick();
        chk("abort.gnt", 32'(Gnt), 32'h1);
        tick();
        tick();
        tick();
        RS = 1'b0; Req = 2'b00;
        tick();
        chk("abort.gnt_rst", 32'(Gnt), 32'd0);
        chk("abort.valid", 32'(Valid), 32'd0);
        chk("abort.dout", 32'(Dout), 32'd0);
        chk("abort.busy", 32'(Busy), 32'd0);
        RS = 1'b1;
        tick();
        tick();
        chk("abort.no_late_valid", 32'(Valid), 32'd0);
        // Pointer reset to 0, so requester 0 wins the tie; Q restarted from zero.
        Req = 2'b11;
        do_txn("post_rst", 2'b01, 8'h90, 0);
        Req = 2'b00;

        // Req dropped and SeedLd pulsed mid-shift: byte from 90 completes as 09.
        Req = 2'b01;
        do_txn("disturb", 2'b01, 8'h09, 3);
        tick();
        chk("disturb.no_regrant", 32'(Gnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
